// File: rtl/rng_scheduler_if.sv
// rng_scheduler_if: requester/generator bundle between the scheduler (slave) and its environment (master).
//   req       : per-requester request level, held until ack
//   req_min/max: packed bounds, slice i = [i*WIDTH +: WIDTH]
//   ack/rnd_data/range_err: one-cycle completion with result
//   busy      : scheduler not idle
//   rng_enable/rng_min/rng_max/rng_value: shared generator link
interface rng_scheduler_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_min;
  logic [N_REQ*WIDTH-1:0] req_max;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       rnd_data;
  logic                   range_err;
  logic                   busy;
  logic                   rng_enable;
  logic [WIDTH-1:0]       rng_min;
  logic [WIDTH-1:0]       rng_max;
  logic [WIDTH-1:0]       rng_value;
  modport slave (
    input  req, req_min, req_max, rng_value,
    output ack, rnd_data, range_err, busy, rng_enable, rng_min, rng_max
  );
  modport master (
    output req, req_min, req_max, rng_value,
    input  ack, rnd_data, range_err, busy, rng_enable, rng_min, rng_max
  );
endinterface

// File: rtl/rng_scheduler.sv
// rng_scheduler: round-robin arbiter sharing one bounded random generator among N_REQ requesters.
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : rng_scheduler_if.slave (requests, bounds, ack/result, generator link)
module rng_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input logic            clk,
  input logic            reset,
  rng_scheduler_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;
  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    grant_q, grant_d, last_q, last_d;
  logic [WIDTH-1:0] data_q, data_d, min_q, min_d, max_q, max_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mins [N_REQ];
  logic [WIDTH-1:0] maxs [N_REQ];
  logic             found, bad;
  logic [IW-1:0]    pick, cand;
  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign mins[i] = bus.req_min[i*WIDTH +: WIDTH];
    assign maxs[i] = bus.req_max[i*WIDTH +: WIDTH];
  end
  // Search starts one past the last grant so every requester is reached within N_REQ grants.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % N_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end
  assign bad = maxs[pick] < mins[pick];
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    data_d  = data_q;
    min_d   = min_q;
    max_d   = max_q;
    err_d   = err_q;
    if (state_q == IDLE && found) begin
      grant_d = pick;
      last_d  = pick;
      min_d   = mins[pick];
      max_d   = maxs[pick];
      err_d   = bad;
      data_d  = bad ? mins[pick] : data_q;
      state_d = bad ? DONE : ISSUE;
    end else if (state_q == ISSUE) begin
      state_d = CAPTURE;
    end else if (state_q == CAPTURE) begin
      data_d  = bus.rng_value;
      state_d = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      data_q  <= '0;
      min_q   <= '0;
      max_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      min_q   <= min_d;
      max_q   <= max_d;
      err_q   <= err_d;
    end
  end
  assign bus.ack        = (state_q == DONE) ? N_REQ'(1) << grant_q : '0;
  assign bus.range_err  = err_q && (state_q == DONE);
  assign bus.rnd_data   = data_q;
  assign bus.busy       = state_q != IDLE;
  assign bus.rng_enable = state_q == ISSUE;
  assign bus.rng_min    = min_q;
  assign bus.rng_max    = max_q;
endmodule

// File: tb/tb_rng_scheduler.sv
// tb_rng_scheduler: directed stimulus with a transaction-level model checked every cycle.
module tb_rng_scheduler;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int passed = 0;
  int total = 0;
  rng_scheduler_if #(.N_REQ(N), .WIDTH(W)) bif ();
  rng_scheduler #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bif));
  always #5 clk = ~clk;
  // Generator stand-in: midpoint of the presented bounds, one cycle after an enabled edge.
  always @(posedge clk) if (bif.rng_enable) bif.rng_value <= bif.rng_min + (bif.rng_max - bif.rng_min) / 2;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  // Model: one transaction record with its grant cycle; outputs follow from latency rules.
  int cyc = 0;
  bit act_m = 0;
  bit terr;
  int tg, tcyc, tlat, last_m;
  logic [W-1:0] o_min, o_max, o_dat, t_min, t_max, t_dat;
  always @(negedge clk) begin
    int rel, g;
    bit fin;
    logic [N-1:0] e_ack;
    if (!reset) begin
      chk("rst_ack", 64'(bif.ack), 64'(0));
      chk("rst_busy", 64'(bif.busy), 64'(0));
      chk("rst_en", 64'(bif.rng_enable), 64'(0));
      chk("rst_err", 64'(bif.range_err), 64'(0));
      chk("rst_data", 64'(bif.rnd_data), 64'(0));
      chk("rst_min", 64'(bif.rng_min), 64'(0));
      chk("rst_max", 64'(bif.rng_max), 64'(0));
      act_m = 0; last_m = N - 1; o_min = '0; o_max = '0; o_dat = '0;
    end else begin
      rel = cyc - tcyc;
      fin = act_m && rel == tlat;
      e_ack = fin ? N'(1) << tg : '0;
      chk("ack", 64'(bif.ack), 64'(e_ack));
      chk("rng_enable", 64'(bif.rng_enable), 64'(act_m && !terr && rel == 1));
      chk("busy", 64'(bif.busy), 64'(act_m && rel >= 1));
      chk("range_err", 64'(bif.range_err), 64'(fin && terr));
      chk("rnd_data", 64'(bif.rnd_data), 64'(fin ? t_dat : o_dat));
      chk("rng_min", 64'(bif.rng_min), 64'((act_m && rel >= 1) ? t_min : o_min));
      chk("rng_max", 64'(bif.rng_max), 64'((act_m && rel >= 1) ? t_max : o_max));
      if (fin) begin
        act_m = 0; o_dat = t_dat; o_min = t_min; o_max = t_max;
      end else if (!act_m && bif.req != 0) begin
        g = -1;
        for (int k = 1; k <= N; k++) if (g < 0 && bif.req[(last_m + k) % N]) g = (last_m + k) % N;
        act_m = 1; tcyc = cyc; tg = g; last_m = g;
        t_min = bif.req_min[g*W +: W];
        t_max = bif.req_max[g*W +: W];
        terr = t_max < t_min;
        tlat = terr ? 1 : 3;
        t_dat = terr ? t_min : t_min + (t_max - t_min) / 2;
      end
    end
    cyc++;
  end
  task automatic set_b(input int i, input logic [W-1:0] mn, input logic [W-1:0] mx);
    bif.req_min[i*W +: W] = mn;
    bif.req_max[i*W +: W] = mx;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic wait_ack(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (bif.ack == 0 && n < 20);
    chk("ack_seen", 64'(bif.ack != 0), 64'(1));
  endtask
  int n;
  initial begin
    bif.req = '0; bif.req_min = '0; bif.req_max = '0; bif.rng_value = '0;
    bif.req = 4'b0011;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_busy_with_req", 64'(bif.busy), 64'(0));
    chk("reset_ack_with_req", 64'(bif.ack), 64'(0));
    bif.req = '0;
    step(); reset = 1'b1;
    step();
    set_b(0, 10, 20); bif.req = 4'b0001;
    @(negedge clk);
    chk("single_T_en", 64'(bif.rng_enable), 64'(0));
    @(negedge clk);
    chk("single_T1_en", 64'(bif.rng_enable), 64'(1));
    chk("single_T1_min", 64'(bif.rng_min), 64'(10));
    chk("single_T1_max", 64'(bif.rng_max), 64'(20));
    @(negedge clk);
    @(negedge clk);
    chk("single_T3_ack", 64'(bif.ack), 64'(1));
    chk("single_T3_data", 64'(bif.rnd_data), 64'(15));
    step(); bif.req = '0;
    repeat (2) step();
    reset = 1'b0;
    step(); reset = 1'b1;
    for (int i = 0; i < N; i++) set_b(i, 32'(i * 10), 32'(i * 10 + 8));
    bif.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(n);
      chk("rr_ack", 64'(bif.ack), 64'(4'b0001 << (k % 4)));
      chk("rr_spacing", 64'(n), 64'(4));
      chk("rr_data", 64'(bif.rnd_data), 64'((k % 4) * 10 + 4));
    end
    step(); bif.req = '0;
    step();
    set_b(2, 50, 40); bif.req = 4'b0100;
    @(negedge clk);
    chk("err_T_en", 64'(bif.rng_enable), 64'(0));
    @(negedge clk);
    chk("err_T1_ack", 64'(bif.ack), 64'(4'b0100));
    chk("err_T1_flag", 64'(bif.range_err), 64'(1));
    chk("err_T1_data", 64'(bif.rnd_data), 64'(50));
    step(); bif.req = '0;
    step();
    set_b(2, 5, 9); bif.req = 4'b0100;
    @(negedge clk);
    step(); set_b(2, 99, 9);
    @(negedge clk);
    chk("hold_min", 64'(bif.rng_min), 64'(5));
    wait_ack(n);
    chk("hold_ack", 64'(bif.ack), 64'(4'b0100));
    chk("hold_data", 64'(bif.rnd_data), 64'(7));
    step(); bif.req = '0;
    step();
    set_b(0, 7, 7); bif.req = 4'b0001;
    wait_ack(n);
    chk("eq_ack", 64'(bif.ack), 64'(1));
    chk("eq_lat", 64'(n), 64'(4));
    chk("eq_err", 64'(bif.range_err), 64'(0));
    chk("eq_data", 64'(bif.rnd_data), 64'(7));
    step(); bif.req = '0;
    step();
    set_b(1, 100, 200); bif.req = 4'b0010;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_ack", 64'(bif.ack), 64'(0));
    chk("abort_busy", 64'(bif.busy), 64'(0));
    chk("abort_data", 64'(bif.rnd_data), 64'(0));
    chk("abort_min", 64'(bif.rng_min), 64'(0));
    step();
    chk("abort_ack2", 64'(bif.ack), 64'(0));
    step(); reset = 1'b1;
    wait_ack(n);
    chk("regrant_ack", 64'(bif.ack), 64'(4'b0010));
    chk("regrant_lat", 64'(n), 64'(4));
    chk("regrant_data", 64'(bif.rnd_data), 64'(150));
    step(); bif.req = '0;
    step();
    set_b(3, 1, 3); bif.req = 4'b1010;
    wait_ack(n);
    chk("fair_first", 64'(bif.ack), 64'(4'b1000));
    step(); bif.req = 4'b0010;
    wait_ack(n);
    chk("fair_second", 64'(bif.ack), 64'(4'b0010));
    chk("fair_gap", 64'(n), 64'(4));
    step(); bif.req = '0;
    repeat (3) step();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
